wedge_output_driver: RTL
========================

// Module: wedge_output_driver
// PURPOSE
// Downstream stage of the wedge fitter. Pops fitted-track words from the fitter's output FIFO.
// Drives them onto the outgoing mezzanine link as 23-bit words, each with an active-low data strobe.
// Honours the link's hold, absorbs the FIFO read latency in a skid buffer, counts events and flags errors.
// Word format: bit 22 = EE (end event), bit 21 = EP (end packet), [20:0] = payload.
// PARAMETERS
// SKID_DEPTH   2     skid buffer entries; must be >= 2 (one FIFO read in flight plus one held word)
// TIMEOUT      1024  idle cycles allowed mid-event before err_timeout sets
// CNT_W        16    event_count width
// PORTS
// clock        in   1      system clock; all logic on rising edge
// reset        in   1      synchronous, active-high; clears all state
// fit_empty    in   1      fitter output FIFO empty
// fit_valid    in   1      fit_data valid; arrives 1 cycle after a fit_re
// fit_data     in   23     word read from the fitter FIFO
// fit_re       out  1      FIFO read enable, one word per asserted cycle
// hold_in      in   1      downstream hold, active-high
// link_data    out  23     outgoing link word
// link_ds_n    out  1      link data strobe, active-low, 1 cycle per word
// event_count  out  CNT_W  number of EE words sent; wraps
// err_timeout  out  1      sticky: event open and no word for TIMEOUT cycles
// err_overrun  out  1      sticky: fit_valid seen while the skid buffer was full
// busy         out  1      skid not empty, OR a read in flight, OR an event open
// BEHAVIOUR
// - Reset values: fit_re=0, link_data=0, link_ds_n=1, event_count=0, err_*=0, busy=0.
//   Reset also clears the skid buffer, the in-flight flag and the timeout counter.
// - Reset mid-event: words in the skid buffer are discarded. No strobe is issued in the reset cycle.
// - Read rule: fit_re = !fit_empty && !hold_in && (occupancy + inflight < SKID_DEPTH).
//   fit_re is combinational from registered state. inflight is a register set by fit_re, cleared the next cycle.
// - Write into skid: on fit_valid, fit_data is pushed.
//   If the skid is full (occupancy == SKID_DEPTH), the word is dropped and err_overrun sets.
// - Send rule: registered output. If the skid is non-empty and hold_in==0, then next cycle:
//   link_data = head word, link_ds_n = 0, and the head is popped. Otherwise link_ds_n=1 and link_data holds its last value.
// - Latency: a word read at cycle t (fit_re=1) appears on the link at t+2 when no hold is asserted.
// - Throughput: 1 word/cycle sustained when the FIFO is non-empty and hold_in=0.
// - Hold: a strobe is never issued in the cycle after a cycle sampled with hold_in=1.
//   Reads stop the same cycle. The in-flight word lands in the skid and no data is lost.
// - Simultaneous push and pop in one cycle: occupancy unchanged, FIFO order preserved.
// - Event tracking: event_open sets on any strobed word with EE=0. It clears on a strobed word with EE=1.
//   event_count increments on each strobed EE word, including an empty event (word 23'h600000).
// - Timeout: the counter increments each cycle that event_open=1 and no strobe is issued. It clears on any strobe.
//   err_timeout sets when the counter reaches TIMEOUT, then the counter saturates. Forwarding continues.
// - err_* flags are cleared only by reset.
// - FSM (send side): IDLE (skid empty) -> SEND (skid non-empty, hold_in=0) -> HELD (hold_in=1, skid non-empty).
//   HELD -> SEND when hold_in falls. SEND -> IDLE when the skid drains and no read is in flight.
// TESTING
// - Reset, then fit_empty=1 for 100 cycles -> fit_re=0, link_ds_n=1, busy=0, event_count=0.
// - FIFO holds 23'h000123, 23'h000456, 23'h600000, hold_in=0 -> three consecutive strobes, first at 2 cycles after the first fit_re.
//   Link words match in order; event_count=1.
// - A 10-word stream with hold_in pulsed high for 5 cycles mid-stream -> no strobe during the hold window plus 1 cycle.
//   All 10 words are delivered in order with none duplicated; err_overrun=0.
// - A word with EE=0 is sent, then fit_empty=1 for TIMEOUT cycles -> err_timeout=1 at cycle TIMEOUT.
//   A subsequent 23'h600000 is still forwarded and event_count increments.
// - fit_valid forced high 3 cycles while hold_in=1 with SKID_DEPTH=2 -> err_overrun=1; the first two words are kept and sent after the hold.
// - Reset asserted while the skid holds 2 words -> next cycle link_ds_n=1, occupancy=0, event_count=0; no stale words are sent.

Source files
------------

// File: rtl/wedge_output_driver_if.sv
// rtl/wedge_output_driver_if.sv - fitter FIFO read port and mezzanine link signals
// Ports:
//   fit_empty, fit_valid, fit_data[22:0]  fitter FIFO status and read data
//   fit_re                                FIFO read enable
//   hold_in                               downstream hold, active-high
//   link_data[22:0], link_ds_n            outgoing link word and active-low strobe
// master: the output driver; slave: the fitter FIFO plus the link receiver.
interface wedge_output_driver_if;
    logic        fit_empty;
    logic        fit_valid;
    logic [22:0] fit_data;
    logic        fit_re;
    logic        hold_in;
    logic [22:0] link_data;
    logic        link_ds_n;

    modport master (
        input  fit_empty,
        input  fit_valid,
        input  fit_data,
        input  hold_in,
        output fit_re,
        output link_data,
        output link_ds_n
    );

    modport slave (
        output fit_empty,
        output fit_valid,
        output fit_data,
        output hold_in,
        input  fit_re,
        input  link_data,
        input  link_ds_n
    );
endinterface

// File: rtl/wedge_output_driver.sv
// rtl/wedge_output_driver.sv - pops fitted-track words into a skid buffer and strobes them onto the link
// Ports:
//   clock        system clock, rising edge
//   reset        synchronous, active-high
//   link         wedge_output_driver_if.master (FIFO read side and link side)
//   event_count  number of EE words sent, wraps
//   err_timeout  sticky: event open with no word for TIMEOUT cycles
//   err_overrun  sticky: fit_valid arrived while the skid was full
//   busy         skid non-empty, read in flight or event open
// Word format: bit 22 = EE, bit 21 = EP, [20:0] = payload.
module wedge_output_driver #(
    parameter int SKID_DEPTH = 2,
    parameter int TIMEOUT    = 1024,
    parameter int CNT_W      = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    wedge_output_driver_if.master link,
    output logic [CNT_W-1:0]     event_count,
    output logic                 err_timeout,
    output logic                 err_overrun,
    output logic                 busy
);
    localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int OCC_W = $clog2(SKID_DEPTH + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(SKID_DEPTH - 1);
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(SKID_DEPTH);
    localparam logic [TO_W-1:0]  TO_MAX    = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_HELD} state_t;

    state_t            state, state_next;
    logic [22:0]       skid [SKID_DEPTH];
    logic [PTR_W-1:0]  head, tail;
    logic [OCC_W-1:0]  occ;
    logic              inflight;
    logic              event_open;
    logic [TO_W-1:0]   to_cnt;

    logic              have_word, send, bypass, pop_skid, push, overrun;
    logic [22:0]       send_word;

    // Reserve one skid slot per outstanding read so the in-flight word always has a home.
    assign link.fit_re = !link.fit_empty && !link.hold_in &&
                         (({1'b0, occ} + {{OCC_W{1'b0}}, inflight}) < {1'b0, DEPTH_OCC});

    assign busy = (occ != '0) || inflight || event_open;

    always_comb begin
        have_word  = (occ != '0) || link.fit_valid;
        send       = have_word && !link.hold_in;
        // With an empty skid the arriving word goes straight out, giving the two-cycle read-to-link latency.
        bypass     = send && (occ == '0);
        pop_skid   = send && (occ != '0);
        push       = link.fit_valid && !bypass && (occ != DEPTH_OCC);
        overrun    = link.fit_valid && !bypass && (occ == DEPTH_OCC);
        send_word  = (occ != '0) ? skid[head] : link.fit_data;

        state_next = state;
        case (state)
            ST_IDLE: if (have_word) state_next = link.hold_in ? ST_HELD : ST_SEND;
            ST_SEND: begin
                if (have_word && link.hold_in)      state_next = ST_HELD;
                else if (!have_word && !inflight)   state_next = ST_IDLE;
            end
            ST_HELD: if (!link.hold_in) state_next = have_word ? ST_SEND : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head           <= '0;
            tail           <= '0;
            occ            <= '0;
            inflight       <= 1'b0;
            event_open     <= 1'b0;
            to_cnt         <= '0;
            event_count    <= '0;
            err_timeout    <= 1'b0;
            err_overrun    <= 1'b0;
            link.link_data <= '0;
            link.link_ds_n <= 1'b1;
        end else begin
            inflight <= link.fit_re;

            if (push) begin
                skid[tail] <= link.fit_data;
                tail       <= (tail == LAST_PTR) ? '0 : tail + PTR_W'(1);
            end
            if (pop_skid) head <= (head == LAST_PTR) ? '0 : head + PTR_W'(1);

            if (push && !pop_skid)      occ <= occ + OCC_W'(1);
            else if (!push && pop_skid) occ <= occ - OCC_W'(1);

            if (overrun) err_overrun <= 1'b1;

            if (send) begin
                link.link_data <= send_word;
                link.link_ds_n <= 1'b0;
                if (send_word[22]) begin
                    event_count <= event_count + CNT_W'(1);
                    event_open  <= 1'b0;
                end else begin
                    event_open  <= 1'b1;
                end
            end else begin
                link.link_ds_n <= 1'b1;
            end

            // Counts the idle cycles of an open event; the current strobe restarts it.
            if (!link.link_ds_n) begin
                to_cnt <= '0;
            end else if (event_open && (to_cnt != TO_MAX)) begin
                to_cnt <= to_cnt + TO_W'(1);
                if (to_cnt == TO_LAST) err_timeout <= 1'b1;
            end
        end
    end
endmodule
